// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for the pong game.
//   Tracks the match state (IDLE, SERVE, RALLY, POINT, PAUSE, OVER) and the
//   packed 2+2 bit score, and drives the shared ball-enable / freeze controls.
// Ports:
//   vga_clk     sole clock
//   sys_rst     synchronous active-high reset
//   frame_tick  one-cycle pulse per frame
//   start_key   start key level (rising edge is the event)
//   pause_key   pause key level (rising edge is the event)
//   miss_left   ball crossed left goal -> right player scores
//   miss_right  ball crossed right goal -> left player scores
//   start       ball motion enable
//   s           freeze paddles and ball
//   score       [3:2] left, [1:0] right
//   serve_dir   0 = toward left, 1 = toward right
//   winner      00 none, 01 left, 10 right
//   game_over   high in OVER
//   blink       score blink phase in OVER, else 0
//   state       debug state code
module pong_game_ctrl #(
    parameter logic [7:0] SERVE_FRAMES = 8'd60,
    parameter logic [7:0] POINT_FRAMES = 8'd90,
    parameter logic [7:0] BLINK_FRAMES = 8'd30,
    parameter logic [1:0] WIN_SCORE    = 2'd3
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       frame_tick,
    input  logic       start_key,
    input  logic       pause_key,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       start,
    output logic       s,
    output logic [3:0] score,
    output logic       serve_dir,
    output logic [1:0] winner,
    output logic       game_over,
    output logic       blink,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        RALLY = 3'd2,
        POINT = 3'd3,
        PAUSE = 3'd4,
        OVER  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] left_q, left_d;
    logic [1:0] right_q, right_d;
    logic       serve_dir_q, serve_dir_d;
    logic [1:0] winner_q, winner_d;
    logic       game_over_q, game_over_d;
    logic       blink_q, blink_d;
    logic       start_q, start_d;
    logic       s_q, s_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       start_key_prev_q, start_key_prev_d;
    logic       pause_key_prev_q, pause_key_prev_d;

    logic start_ev;
    logic pause_ev;
    logic blink_wrap;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    assign start_ev = start_key & ~start_key_prev_q;
    assign pause_ev = pause_key & ~pause_key_prev_q;

    always_comb begin
        state_d          = state_q;
        left_d           = left_q;
        right_d          = right_q;
        serve_dir_d      = serve_dir_q;
        winner_d         = winner_q;
        blink_d          = blink_q;
        start_key_prev_d = start_key;
        pause_key_prev_d = pause_key;
        blink_wrap       = 1'b0;

        case (state_q)
            IDLE: begin
                left_d  = '0;
                right_d = '0;
                if (start_ev) begin
                    state_d     = SERVE;
                    serve_dir_d = 1'b1;
                end
            end
            SERVE: begin
                if (frame_tick && frame_cnt_q == SERVE_FRAMES - 8'd1) begin
                    state_d = RALLY;
                end
            end
            RALLY: begin
                // A miss outranks a same-cycle pause; a double miss scores nobody.
                if (miss_left || miss_right) begin
                    state_d = POINT;
                    if (miss_left && !miss_right) begin
                        right_d     = sat_inc(right_q);
                        serve_dir_d = 1'b0;
                    end else if (miss_right && !miss_left) begin
                        left_d      = sat_inc(left_q);
                        serve_dir_d = 1'b1;
                    end
                end else if (pause_ev) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_ev) begin
                    state_d = RALLY;
                end
            end
            POINT: begin
                if (frame_tick && frame_cnt_q == POINT_FRAMES - 8'd1) begin
                    if (left_q == WIN_SCORE || right_q == WIN_SCORE) begin
                        state_d  = OVER;
                        winner_d = (left_q == WIN_SCORE) ? 2'b01 : 2'b10;
                        blink_d  = 1'b0;
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            OVER: begin
                if (start_ev) begin
                    state_d     = SERVE;
                    left_d      = '0;
                    right_d     = '0;
                    winner_d    = '0;
                    blink_d     = 1'b0;
                    serve_dir_d = 1'b1;
                end else if (frame_tick && frame_cnt_q == BLINK_FRAMES - 8'd1) begin
                    blink_d    = ~blink_q;
                    blink_wrap = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A tick that causes a transition is spent on it, not counted afresh.
        if (state_d != state_q || blink_wrap) begin
            frame_cnt_d = '0;
        end else if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        // Registered control outputs follow the next state.
        start_d     = (state_d == RALLY) || (state_d == PAUSE);
        s_d         = !((state_d == SERVE) || (state_d == RALLY));
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q          <= IDLE;
            left_q           <= '0;
            right_q          <= '0;
            serve_dir_q      <= 1'b1;
            winner_q         <= '0;
            game_over_q      <= 1'b0;
            blink_q          <= 1'b0;
            start_q          <= 1'b0;
            s_q              <= 1'b1;
            frame_cnt_q      <= '0;
            start_key_prev_q <= 1'b1;
            pause_key_prev_q <= 1'b1;
        end else begin
            state_q          <= state_d;
            left_q           <= left_d;
            right_q          <= right_d;
            serve_dir_q      <= serve_dir_d;
            winner_q         <= winner_d;
            game_over_q      <= game_over_d;
            blink_q          <= blink_d;
            start_q          <= start_d;
            s_q              <= s_d;
            frame_cnt_q      <= frame_cnt_d;
            start_key_prev_q <= start_key_prev_d;
            pause_key_prev_q <= pause_key_prev_d;
        end
    end

    assign start     = start_q;
    assign s         = s_q;
    assign score     = {left_q, right_q};
    assign serve_dir = serve_dir_q;
    assign winner    = winner_q;
    assign game_over = game_over_q;
    assign blink     = blink_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: directed match scenario followed by
// randomized key/tick/miss traffic, checked against a rule-level model.
module tb_pong_game_ctrl;

    localparam int SF = 4;
    localparam int PF = 3;
    localparam int BF = 2;
    localparam int WS = 3;

    logic       vga_clk;
    logic       sys_rst;
    logic       frame_tick;
    logic       start_key;
    logic       pause_key;
    logic       miss_left;
    logic       miss_right;
    logic       start;
    logic       s;
    logic [3:0] score;
    logic       serve_dir;
    logic [1:0] winner;
    logic       game_over;
    logic       blink;
    logic [2:0] state;

    pong_game_ctrl #(
        .SERVE_FRAMES(8'(SF)),
        .POINT_FRAMES(8'(PF)),
        .BLINK_FRAMES(8'(BF)),
        .WIN_SCORE   (2'(WS))
    ) dut (
        .vga_clk   (vga_clk),
        .sys_rst   (sys_rst),
        .frame_tick(frame_tick),
        .start_key (start_key),
        .pause_key (pause_key),
        .miss_left (miss_left),
        .miss_right(miss_right),
        .start     (start),
        .s         (s),
        .score     (score),
        .serve_dir (serve_dir),
        .winner    (winner),
        .game_over (game_over),
        .blink     (blink),
        .state     (state)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int errors = 0;
    int checks = 0;
    logic [13:0] exp_q[$];

    // Reference model: match phase as a plain integer 0..5, scores as ints.
    int m_mode, m_l, m_r, m_cnt, m_win;
    bit m_dir, m_blink, m_psk, m_ppk;

    function automatic logic [13:0] model_outputs();
        logic st, fr, ov;
        logic [1:0] l2, r2, w2;
        logic [2:0] md;
        st = (m_mode == 2 || m_mode == 4);
        fr = !(m_mode == 1 || m_mode == 2);
        ov = (m_mode == 5);
        l2 = 2'(m_l);
        r2 = 2'(m_r);
        w2 = 2'(m_win);
        md = 3'(m_mode);
        return {st, fr, l2, r2, m_dir, w2, ov, m_blink, md};
    endfunction

    task automatic model_step(input bit r, input bit sk, input bit pk,
                              input bit ft, input bit ml, input bit mr);
        bit sev, pev, wrap;
        int nm;
        if (r) begin
            m_mode = 0; m_l = 0; m_r = 0; m_dir = 1; m_win = 0;
            m_blink = 0; m_cnt = 0; m_psk = 1; m_ppk = 1;
            return;
        end
        sev  = sk && !m_psk;
        pev  = pk && !m_ppk;
        nm   = m_mode;
        wrap = 0;
        case (m_mode)
            0: begin
                m_l = 0; m_r = 0;
                if (sev) begin nm = 1; m_dir = 1; end
            end
            1: if (ft && m_cnt == SF - 1) nm = 2;
            2: begin
                if (ml || mr) begin
                    nm = 3;
                    if (ml && !mr) begin m_r = (m_r < 3) ? m_r + 1 : 3; m_dir = 0; end
                    if (mr && !ml) begin m_l = (m_l < 3) ? m_l + 1 : 3; m_dir = 1; end
                end else if (pev) nm = 4;
            end
            4: if (pev) nm = 2;
            3: if (ft && m_cnt == PF - 1) begin
                if (m_l == WS || m_r == WS) begin
                    nm = 5; m_win = (m_l == WS) ? 1 : 2;
                end else nm = 1;
            end
            5: begin
                if (sev) begin
                    nm = 1; m_l = 0; m_r = 0; m_win = 0; m_blink = 0; m_dir = 1;
                end else if (ft && m_cnt == BF - 1) begin
                    m_blink = !m_blink; wrap = 1;
                end
            end
            default: nm = 0;
        endcase
        if (nm != m_mode || wrap) m_cnt = 0;
        else if (ft) m_cnt = (m_cnt + 1) % 256;
        m_mode = nm;
        m_psk = sk;
        m_ppk = pk;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input bit r, input bit sk, input bit pk,
                        input bit ft, input bit ml, input bit mr);
        @(negedge vga_clk);
        sys_rst = r; start_key = sk; pause_key = pk;
        frame_tick = ft; miss_left = ml; miss_right = mr;
        model_step(r, sk, pk, ft, ml, mr);
        exp_q.push_back(model_outputs());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
    endtask

    // Monitor: compares every queued expectation just after the clock edge.
    initial begin
        logic [13:0] e;
        logic [13:0] got;
        forever begin
            @(posedge vga_clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {start, s, score, serve_dir, winner, game_over, blink, state};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t {start,s,score,dir,winner,over,blink,state}: got %b exp %b",
                             $time, got, e);
                end
            end
        end
    end

    initial begin
        sys_rst = 1; start_key = 1; pause_key = 1;
        frame_tick = 0; miss_left = 0; miss_right = 0;
        m_mode = 0; m_l = 0; m_r = 0; m_dir = 1; m_win = 0;
        m_blink = 0; m_cnt = 0; m_psk = 1; m_ppk = 1;

        // Reset with start key held, release while still held: no serve.
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);   // start edge -> SERVE
        step(0, 0, 0, 0, 0, 0);
        ticks(3);                 // still SERVE
        ticks(1);                 // -> RALLY
        step(0, 0, 0, 0, 1, 0);   // miss_left -> right scores
        ticks(PF);                // -> SERVE
        ticks(SF);
        step(0, 0, 0, 0, 1, 1);   // double miss -> POINT, no score
        ticks(PF);
        ticks(SF);
        step(0, 0, 1, 0, 0, 1);   // miss_right beats pause edge
        step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            ticks(PF);
            ticks(SF);
            step(0, 0, 0, 0, 0, 1);
        end
        ticks(PF);                // left at 3 -> OVER
        ticks(2 * BF + 1);        // blink toggles
        step(0, 1, 0, 0, 0, 0);   // restart
        step(0, 0, 0, 0, 0, 0);
        ticks(SF);                // RALLY
        step(0, 0, 1, 0, 0, 0);   // pause
        step(0, 0, 0, 0, 1, 0);   // ignored miss
        step(0, 0, 0, 1, 0, 1);   // ignored miss with tick
        step(0, 0, 1, 0, 0, 0);   // resume
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);   // pause again
        step(1, 0, 0, 0, 0, 0);   // reset mid-PAUSE
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r, sk, pk, ft, ml, mr;
            r  = ($urandom_range(0, 599) == 0);
            sk = ($urandom_range(0, 5) == 0) ? !start_key : start_key;
            pk = ($urandom_range(0, 7) == 0) ? !pause_key : pause_key;
            ft = ($urandom_range(0, 1) == 0);
            ml = ($urandom_range(0, 11) == 0);
            mr = ($urandom_range(0, 11) == 0);
            step(r, sk, pk, ft, ml, mr);
        end

        repeat (3) @(posedge vga_clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
